// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle instruction sequencer. It walks each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. It also owns the program counter
// and two performance counters.
//
// Ports
//   local_clock              clock; every state update happens on its rising edge
//   reset                    synchronous, active-high; returns to IDLE
//   start                    one-cycle pulse that leaves IDLE
//   im_ready                 instruction memory data valid (only looked at in FETCH)
//   dm_ready                 data memory access complete (only looked at in MEM)
//   is_mem/is_branch/is_halt decoder flags, sampled in DECODE
//   zero                     ALU zero flag, sampled in EXEC
//   pc_set                   signed branch offset in halfwords
//   pc                       current instruction address
//   im_req/ir_enable/
//   dm_req/rf_we             datapath strobes (all registered)
//   halted                   high while in HALT
//   cycle_cnt/instr_cnt      active-cycle and retired-instruction counters
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int unsigned IM_START  = 'h80,
    parameter int          ADDR_SIZE = 10,
    parameter int          DATA_SIZE = 32,
    parameter int          CNT_SIZE  = 32
) (
    input  logic                 local_clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 im_ready,
    input  logic                 dm_ready,
    input  logic                 is_mem,
    input  logic                 is_branch,
    input  logic                 is_halt,
    input  logic                 zero,
    input  logic [DATA_SIZE-1:0] pc_set,
    output logic [ADDR_SIZE-1:0] pc,
    output logic                 im_req,
    output logic                 ir_enable,
    output logic                 dm_req,
    output logic                 rf_we,
    output logic                 halted,
    output logic [CNT_SIZE-1:0]  cycle_cnt,
    output logic [CNT_SIZE-1:0]  instr_cnt
);

    localparam int EXT_W = ADDR_SIZE + DATA_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t               state;
    logic                 mem_flag;
    logic                 branch_flag;
    logic                 take_branch;
    logic [EXT_W-1:0]     offset_ext;
    logic [ADDR_SIZE-1:0] next_pc;

    // Next sequential/branch address. The offset is sign-extended wider than
    // the PC before the halfword shift, so narrow offset widths still work.
    // The sum is then truncated, which gives wrap-around modulo 2^ADDR_SIZE.
    always_comb begin
        offset_ext = {{ADDR_SIZE{pc_set[DATA_SIZE-1]}}, pc_set};
        if (take_branch) begin
            next_pc = ADDR_SIZE'(EXT_W'(pc) + (offset_ext << 1));
        end else begin
            next_pc = pc + ADDR_SIZE'(4);
        end
    end

    // Sequencer FSM. Each strobe is registered together with the state it
    // belongs to, so im_req/dm_req/rf_we/halted line up exactly with
    // FETCH/MEM/WB/HALT. ir_enable is raised by the FETCH handshake, so it is
    // high during the single DECODE cycle that follows.
    always_ff @(posedge local_clock) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= ADDR_SIZE'(IM_START);
            cycle_cnt   <= '0;
            instr_cnt   <= '0;
            mem_flag    <= 1'b0;
            branch_flag <= 1'b0;
            take_branch <= 1'b0;
            im_req      <= 1'b0;
            ir_enable   <= 1'b0;
            dm_req      <= 1'b0;
            rf_we       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (state != IDLE && state != HALT) begin
                cycle_cnt <= cycle_cnt + CNT_SIZE'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FETCH;
                        im_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (im_ready) begin
                        state     <= DECODE;
                        im_req    <= 1'b0;
                        ir_enable <= 1'b1;
                    end
                end
                DECODE: begin
                    ir_enable <= 1'b0;
                    // A halt overrides the other decoder flags.
                    if (is_halt) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        mem_flag    <= 1'b0;
                        branch_flag <= 1'b0;
                    end else begin
                        state       <= EXEC;
                        mem_flag    <= is_mem;
                        branch_flag <= is_branch;
                    end
                end
                EXEC: begin
                    take_branch <= branch_flag & zero;
                    if (mem_flag) begin
                        state  <= MEM;
                        dm_req <= 1'b1;
                    end else begin
                        state <= WB;
                        rf_we <= 1'b1;
                    end
                end
                MEM: begin
                    if (dm_ready) begin
                        state  <= WB;
                        dm_req <= 1'b0;
                        rf_we  <= 1'b1;
                    end
                end
                WB: begin
                    state     <= FETCH;
                    rf_we     <= 1'b0;
                    im_req    <= 1'b1;
                    pc        <= next_pc;
                    instr_cnt <= instr_cnt + CNT_SIZE'(1);
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state     <= IDLE;
                    im_req    <= 1'b0;
                    ir_enable <= 1'b0;
                    dm_req    <= 1'b0;
                    rf_we     <= 1'b0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Self-checking bench for instr_sequencer. Instructions are driven through
// the fetch/memory handshakes, and the results are compared with a small
// reference model of the architectural effects:
//   - pc after each retire
//   - retired-instruction count
//   - active-cycle count
//   - number of strobe pulses per instruction
// Decoder flags and the zero flag carry random values outside the cycle in
// which they matter. The ready inputs carry random values outside their
// handshake states.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int ADDR_SIZE = 10;
    localparam int DATA_SIZE = 32;
    localparam int CNT_SIZE  = 32;
    localparam logic [ADDR_SIZE-1:0] START_PC = 10'h080;

    logic                 local_clock = 1'b0;
    logic                 reset       = 1'b1;
    logic                 start       = 1'b0;
    logic                 im_ready    = 1'b0;
    logic                 dm_ready    = 1'b0;
    logic                 is_mem      = 1'b0;
    logic                 is_branch   = 1'b0;
    logic                 is_halt     = 1'b0;
    logic                 zero        = 1'b0;
    logic [DATA_SIZE-1:0] pc_set      = '0;
    logic [ADDR_SIZE-1:0] pc;
    logic                 im_req;
    logic                 ir_enable;
    logic                 dm_req;
    logic                 rf_we;
    logic                 halted;
    logic [CNT_SIZE-1:0]  cycle_cnt;
    logic [CNT_SIZE-1:0]  instr_cnt;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state
    logic [ADDR_SIZE-1:0] m_pc;
    logic [CNT_SIZE-1:0]  m_cyc;
    logic [CNT_SIZE-1:0]  m_instr;

    instr_sequencer #(
        .IM_START (32'h80),
        .ADDR_SIZE(ADDR_SIZE),
        .DATA_SIZE(DATA_SIZE),
        .CNT_SIZE (CNT_SIZE)
    ) dut (
        .local_clock(local_clock),
        .reset      (reset),
        .start      (start),
        .im_ready   (im_ready),
        .dm_ready   (dm_ready),
        .is_mem     (is_mem),
        .is_branch  (is_branch),
        .is_halt    (is_halt),
        .zero       (zero),
        .pc_set     (pc_set),
        .pc         (pc),
        .im_req     (im_req),
        .ir_enable  (ir_enable),
        .dm_req     (dm_req),
        .rf_we      (rf_we),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 local_clock = ~local_clock;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_pc    = START_PC;
        m_cyc   = '0;
        m_instr = '0;
    endtask

    // Holds reset for two edges (with start also high), then releases it on a
    // falling edge and checks the idle/reset state.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        start = 1'b1;
        @(negedge local_clock);
        @(negedge local_clock);
        reset = 1'b0;
        start = 1'b0;
        model_reset();
        check_output({tag, "_pc"}, 64'(pc), 64'(m_pc));
        check_output({tag, "_cyc"}, 64'(cycle_cnt), 64'(m_cyc));
        check_output({tag, "_instr"}, 64'(instr_cnt), 64'(m_instr));
        check_output({tag, "_strobes"}, 64'({im_req, ir_enable, dm_req, rf_we, halted}), 64'(0));
    endtask

    // Pulse start from IDLE; returns on the falling edge of the first FETCH cycle.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge local_clock);
        start = 1'b0;
    endtask

    // Runs one non-halt instruction. Entry and exit are both on the falling
    // edge of a FETCH cycle.
    //  - im_ready is given on FETCH cycle fetch_wait+1.
    //  - dm_ready is given on MEM cycle mem_wait+1.
    task automatic run_instr(input string tag, input bit mem, input bit br, input bit z,
                             input logic [DATA_SIZE-1:0] off, input int fetch_wait,
                             input int mem_wait);
        int fetch_seen = 0;
        int ir_seen    = 0;
        int dm_seen    = 0;
        int rf_seen    = 0;
        int since_ir   = -1;
        bit done       = 1'b0;
        bit overlap    = 1'b0;
        logic [DATA_SIZE-1:0] target;
        pc_set = off;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (int'(im_req) + int'(dm_req) + int'(rf_we) > 1) overlap = 1'b1;
            if (rf_seen > 0 && im_req) begin
                done = 1'b1;
                break;
            end
            if (im_req)    fetch_seen++;
            if (ir_enable) ir_seen++;
            if (dm_req)    dm_seen++;
            if (rf_we)     rf_seen++;
            im_ready = im_req ? (fetch_seen == fetch_wait + 1) : 1'($urandom_range(1));
            dm_ready = dm_req ? (dm_seen == mem_wait + 1) : 1'($urandom_range(1));
            if (ir_enable) begin
                since_ir  = 0;
                is_mem    = mem;
                is_branch = br;
                is_halt   = 1'b0;
            end else begin
                if (since_ir >= 0) since_ir++;
                is_mem    = 1'($urandom_range(1));
                is_branch = 1'($urandom_range(1));
                is_halt   = 1'($urandom_range(1));
            end
            zero = (since_ir == 1) ? z : 1'($urandom_range(1));
            @(negedge local_clock);
        end
        // Reference model: architectural effect of retiring this instruction
        target  = DATA_SIZE'(m_pc) + (off << 1);
        m_pc    = (br && z) ? target[ADDR_SIZE-1:0] : m_pc + 10'd4;
        m_instr = m_instr + 1;
        m_cyc   = m_cyc + CNT_SIZE'(fetch_wait + 1 + 3 + (mem ? mem_wait + 1 : 0));
        check_output({tag, "_done"}, 64'(done), 64'(1));
        check_output({tag, "_pc"}, 64'(pc), 64'(m_pc));
        check_output({tag, "_instr"}, 64'(instr_cnt), 64'(m_instr));
        check_output({tag, "_cyc"}, 64'(cycle_cnt), 64'(m_cyc));
        check_output({tag, "_fetch_cycles"}, 64'(fetch_seen), 64'(fetch_wait + 1));
        check_output({tag, "_ir_pulses"}, 64'(ir_seen), 64'(1));
        check_output({tag, "_dm_cycles"}, 64'(dm_seen), 64'(mem ? mem_wait + 1 : 0));
        check_output({tag, "_rf_pulses"}, 64'(rf_seen), 64'(1));
        check_output({tag, "_overlap"}, 64'(overlap), 64'(0));
    endtask

    initial begin
        logic [ADDR_SIZE-1:0] diff;
        bit                   bad;
        int                   dm_seen;
        bit                   got;

        // Reset, with start asserted at the same time
        apply_reset("reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge local_clock);
        end
        check_output("idle_no_fetch", 64'(im_req), 64'(0));
        check_output("idle_cyc", 64'(cycle_cnt), 64'(0));

        // First instruction: im_ready arrives on the 2nd FETCH cycle
        pulse_start();
        check_output("start_fetch", 64'(im_req), 64'(1));
        run_instr("alu0", 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1, 0);
        check_output("alu0_pc_84", 64'(pc), 64'(10'h084));
        check_output("alu0_cyc_5", 64'(cycle_cnt), 64'(5));

        // Taken branch back to 0x80, then the same branch not taken
        run_instr("br_taken", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 0, 0);
        run_instr("alu1", 1'b0, 1'b0, 1'b0, 32'h0000_0000, 0, 0);
        run_instr("br_not_taken", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 2, 0);

        // Load where dm_ready arrives on the 4th MEM cycle
        run_instr("load_wait3", 1'b1, 1'b0, 1'b0, 32'h0000_0000, 0, 3);

        // Branch to 0x3FC, then let the sequential step wrap to 0x000
        diff = 10'h3FC - m_pc;
        run_instr("br_to_3fc", 1'b0, 1'b1, 1'b1, DATA_SIZE'(diff >> 1), 0, 0);
        run_instr("wrap_seq", 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1, 0);
        run_instr("br_to_100", 1'b0, 1'b1, 1'b1, 32'h0000_0080, 0, 0);
        run_instr("wrap_branch", 1'b0, 1'b1, 1'b1, 32'h0000_0200, 0, 0);

        // Random instruction mix
        for (int i = 0; i < 12; i++) begin
            run_instr($sformatf("rand%0d", i), 1'($urandom_range(1)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), DATA_SIZE'($urandom), $urandom_range(3),
                      $urandom_range(3));
        end

        // Halt instruction
        got = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (halted) begin
                got = 1'b1;
                break;
            end
            im_ready  = im_req ? 1'b1 : 1'($urandom_range(1));
            is_halt   = ir_enable;
            is_mem    = 1'($urandom_range(1));
            is_branch = 1'($urandom_range(1));
            @(negedge local_clock);
        end
        m_cyc = m_cyc + 2;
        check_output("halt_reached", 64'(got), 64'(1));
        check_output("halt_cyc", 64'(cycle_cnt), 64'(m_cyc));
        check_output("halt_instr", 64'(instr_cnt), 64'(m_instr));
        check_output("halt_pc", 64'(pc), 64'(m_pc));

        // HALT is terminal: start and ready inputs are ignored
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start    = (i % 2 == 0) ? 1'b1 : 1'($urandom_range(1));
            im_ready = 1'($urandom_range(1));
            dm_ready = 1'($urandom_range(1));
            @(negedge local_clock);
            if (im_req || ir_enable || dm_req || rf_we || !halted) bad = 1'b1;
        end
        start = 1'b0;
        check_output("halt_hold", 64'(bad), 64'(0));
        check_output("halt_cyc_frozen", 64'(cycle_cnt), 64'(m_cyc));
        check_output("halt_instr_frozen", 64'(instr_cnt), 64'(m_instr));
        check_output("halt_pc_frozen", 64'(pc), 64'(m_pc));

        apply_reset("halt_reset");
        @(negedge local_clock);
        check_output("halt_reset_idle", 64'({im_req, halted}), 64'(0));

        // Reset in the middle of a MEM wait
        pulse_start();
        pc_set  = '0;
        dm_seen = 0;
        for (int cyc = 0; cyc < 50 && dm_seen < 2; cyc++) begin
            im_ready = im_req;
            is_mem   = ir_enable;
            is_halt  = 1'b0;
            dm_ready = 1'b0;
            @(negedge local_clock);
            if (dm_req) dm_seen++;
        end
        check_output("abort_in_mem", 64'(dm_seen), 64'(2));
        reset = 1'b1;
        @(negedge local_clock);
        reset    = 1'b0;
        dm_ready = 1'b1;
        model_reset();
        check_output("abort_dm_req", 64'(dm_req), 64'(0));
        check_output("abort_cnts", 64'({cycle_cnt, instr_cnt}), 64'(0));
        check_output("abort_pc", 64'(pc), 64'(m_pc));
        @(negedge local_clock);
        dm_ready = 1'b0;
        check_output("abort_late_ready", 64'({im_req, dm_req, rf_we}), 64'(0));
        check_output("abort_still_idle_cyc", 64'(cycle_cnt), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
